// File: rtl/pwm_cmp_sched.sv
// Timebase and compare scheduler for pwmOC: double-buffered duty setpoint,
// applied at period wrap with first-order fractional dither.
module pwm_cmp_sched #(
  parameter int unsigned WIDTH  = 17,
  parameter int unsigned PERIOD = 100000,
  parameter int unsigned FRAC   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [WIDTH+FRAC:0]   sp_data,
  input  logic                  sp_valid,
  output logic                  sp_ready,
  output logic [WIDTH-1:0]      tb,
  output logic [WIDTH-1:0]      cmpH,
  output logic [WIDTH:0]        cmpL,
  output logic                  period_start
);

  localparam int unsigned SPW = WIDTH + 1 + FRAC;
  localparam logic [WIDTH-1:0] TB_LAST = WIDTH'(PERIOD - 1);
  localparam logic [WIDTH+1:0] CLAMP   = (WIDTH + 2)'(2 * PERIOD);

  logic [WIDTH-1:0] tb_q, tb_d;
  logic             ps_q, ps_d;
  logic [SPW-1:0]   shadow_q, shadow_d;
  logic             full_q, full_d;
  logic [SPW-1:0]   active_q, active_d;
  logic [FRAC-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0] cmph_q, cmph_d;
  logic [WIDTH:0]   cmpl_q, cmpl_d;

  logic             accept;
  logic             wrap;
  logic [SPW-1:0]   src;
  logic [FRAC:0]    s;
  logic [WIDTH+1:0] dd;

  always_comb begin
    tb_d     = tb_q;
    ps_d     = 1'b0;
    shadow_d = shadow_q;
    full_d   = full_q;
    active_d = active_q;
    acc_d    = acc_q;
    cmph_d   = cmph_q;
    cmpl_d   = cmpl_q;

    accept = sp_valid && !full_q;
    wrap   = en && (tb_q == TB_LAST);
    src    = full_q ? shadow_q : active_q;
    s      = {1'b0, acc_q} + {1'b0, src[FRAC-1:0]};
    dd     = {1'b0, src[SPW-1:FRAC]} + (WIDTH + 2)'(s[FRAC]);

    if (en) begin
      tb_d = wrap ? '0 : tb_q + WIDTH'(1);
      ps_d = wrap;
    end else begin
      tb_d   = '0;
      cmph_d = '1;
      cmpl_d = '1;
      acc_d  = '0;
    end

    if (wrap) begin
      acc_d    = s[FRAC-1:0];
      active_d = src;
      full_d   = 1'b0;
      if (dd == '0) begin
        cmph_d = '1;
        cmpl_d = '1;
      end else if (dd >= CLAMP) begin
        cmph_d = '0;
        cmpl_d = '1;
      end else begin
        cmph_d = '0;
        cmpl_d = dd[WIDTH:0];
      end
    end

    // accept is gated by !full_q, so it never collides with the wrap
    // consuming the shadow; an accept on the wrap edge waits a period.
    if (accept) begin
      shadow_d = sp_data;
      full_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tb_q     <= '0;
      ps_q     <= 1'b0;
      shadow_q <= '0;
      full_q   <= 1'b0;
      active_q <= '0;
      acc_q    <= '0;
      cmph_q   <= '1;
      cmpl_q   <= '1;
    end else begin
      tb_q     <= tb_d;
      ps_q     <= ps_d;
      shadow_q <= shadow_d;
      full_q   <= full_d;
      active_q <= active_d;
      acc_q    <= acc_d;
      cmph_q   <= cmph_d;
      cmpl_q   <= cmpl_d;
    end
  end

  assign sp_ready     = !full_q;
  assign tb           = tb_q;
  assign cmpH         = cmph_q;
  assign cmpL         = cmpl_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_cmp_sched.sv
// Scoreboard bench: stimulus queues the compare pair expected after each
// wrap; a monitor pops and checks it on every period_start strobe.
module tb_pwm_cmp_sched;
  localparam int unsigned W = 8;
  localparam int unsigned P = 200;
  localparam int unsigned F = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic [W+F:0]   sp_data = '0;
  logic           sp_valid = 1'b0;
  logic           sp_ready;
  logic [W-1:0]   tb;
  logic [W-1:0]   cmpH;
  logic [W:0]     cmpL;
  logic           period_start;

  pwm_cmp_sched #(.WIDTH(W), .PERIOD(P), .FRAC(F)) dut (
    .clk(clk), .rst(rst), .en(en), .sp_data(sp_data), .sp_valid(sp_valid),
    .sp_ready(sp_ready), .tb(tb), .cmpH(cmpH), .cmpL(cmpL),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] h;
    logic [W:0]   l;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input int h, input int l);
    exp_t e;
    e.h = W'(h);
    e.l = (W + 1)'(l);
    q.push_back(e);
  endtask

  task automatic wait_tb(input int v);
    int n = 0;
    while (tb != W'(v) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("wait_tb_timeout", tb, v);
  endtask

  task automatic wait_wrap(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 1000);
    if (!period_start) check("wrap_timeout", period_start, 1);
  endtask

  task automatic offer(input int d, input int f, output int held);
    logic [W:0]   dv;
    logic [F-1:0] fv;
    dv = (W + 1)'(d);
    fv = F'(f);
    sp_data  = {dv, fv};
    sp_valid = 1'b1;
    held = 0;
    while (!sp_ready && held < 1000) begin
      @(negedge clk);
      held++;
    end
    if (!sp_ready) check("offer_timeout", sp_ready, 1);
    @(negedge clk);
    sp_valid = 1'b0;
  endtask

  // Monitor
  initial begin
    exp_t e;
    exp_t cur;
    bit   have = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (rst || !en) begin
        have = 1'b0;
      end else if (period_start) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_period: strobe at tb=%0d, required none", tb);
        end else begin
          e = q.pop_front();
          check("tb_at_strobe", tb, 0);
          check("cmpH", cmpH, e.h);
          check("cmpL", cmpL, e.l);
          cur  = e;
          have = 1'b1;
        end
      end else if (have && tb == W'(P / 2)) begin
        check("cmpH_hold", cmpH, cur.h);
        check("cmpL_hold", cmpL, cur.l);
      end
    end
  end

  // Stimulus
  initial begin
    int n;
    int held;
    int ones;

    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_tb", tb, 0);
    check("rst_ps", period_start, 0);
    check("rst_ready", sp_ready, 1);
    check("rst_cmpH", cmpH, 'hFF);
    check("rst_cmpL", cmpL, 'h1FF);
    rst = 1'b0;
    en  = 1'b1;

    // no setpoint: off, one strobe per PERIOD cycles
    push('hFF, 'h1FF);
    wait_wrap(n);
    push('hFF, 'h1FF);
    wait_wrap(n);
    check("period_len", n, P);

    // D=101 accepted mid-period
    wait_tb(50);
    check("ready_before", sp_ready, 1);
    push(0, 'h065);
    offer(101, 0, held);
    check("ready_after_accept", sp_ready, 0);
    wait_tb(P - 1);
    check("ready_at_last", sp_ready, 0);
    wait_wrap(n);
    check("ready_after_wrap", sp_ready, 1);

    // dither D=100 frac=0.25 over 8 periods
    offer(100, 1, held);
    ones = 0;
    for (int i = 1; i <= 8; i++) begin
      push(0, (i % 4 == 0) ? 101 : 100);
      wait_wrap(n);
      ones += int'(cmpL[0]);
    end
    check("dither_ones", ones, 2);

    // clamp and zero
    offer(400, 0, held);
    push(0, 'h1FF);
    wait_wrap(n);
    offer(0, 0, held);
    push('hFF, 'h1FF);
    wait_wrap(n);

    // back-to-back offers
    push(0, 10);
    offer(10, 0, held);
    check("ready_full", sp_ready, 0);
    offer(20, 0, held);
    check("holdoff_cycles", held, P - 1);
    push(0, 20);
    wait_wrap(n);

    // accept coinciding with the update edge waits one period
    push(0, 20);
    push(0, 30);
    wait_tb(P - 1);
    check("ready_on_update", sp_ready, 1);
    offer(30, 0, held);
    check("coincide_held", held, 0);
    wait_wrap(n);

    // async reset with shadow full
    offer(40, 0, held);
    wait_tb(120);
    rst = 1'b1;
    #1;
    check("arst_tb", tb, 0);
    check("arst_ps", period_start, 0);
    check("arst_ready", sp_ready, 1);
    check("arst_cmpH", cmpH, 'hFF);
    check("arst_cmpL", cmpL, 'h1FF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push('hFF, 'h1FF);
    wait_wrap(n);
    check("post_rst_ready", sp_ready, 1);

    // en=0: timebase held, outputs off, shadow still accepts
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("dis_tb", tb, 0);
    check("dis_ps", period_start, 0);
    check("dis_cmpH", cmpH, 'hFF);
    check("dis_cmpL", cmpL, 'h1FF);
    offer(50, 3, held);
    check("dis_accept_held", held, 0);
    check("dis_ready", sp_ready, 0);
    en = 1'b1;
    push(0, 'h032);
    push(0, 'h033);
    wait_wrap(n);
    wait_wrap(n);

    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
